jump_charge_ctrl: RTL and testbench

Controller that sequences the jump datapath: debounces the player button, measures hold time as a squeeze level, converts it to a launch velocity, and runs the `jump` unit through one enable/done transaction per press. It sits between the top-level button input, `wechat_jump_fsm` (which arms it and consumes squeeze/landing status) and `jump` (which it drives via en/v_init and monitors via done).

---
 rtl/jump_charge_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_jump_charge_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_charge_ctrl.sv
// rtl/jump_charge_ctrl.sv - Button debounce, squeeze charge and jump launch/flight sequencer (optional JUMP_CHARGE_AUTOLAUNCH_EN)
module jump_charge_ctrl #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CHARGE_STEP     = 4096,
    parameter int MAX_LEVEL       = 14,
    parameter int V_MIN           = 16,
    parameter int V_STEP          = 12,
    parameter int TIMEOUT_CYCLES  = 4194304
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_bt,
    input  logic       i_arm,
    input  logic       i_jump_done,
    output logic       o_jump_en,
    output logic [7:0] o_jump_v_init,
    output logic [3:0] o_squeeze,
    output logic       o_busy,
    output logic       o_land_pulse,
    output logic       o_timeout
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STEP_W = $clog2(CHARGE_STEP + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CHARGE_STEP - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        MAX_LVL   = 4'(MAX_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHARGE,
        S_LAUNCH,
        S_FLIGHT,
        S_DONE
    } state_t;

    state_t             state;
    logic               bt_meta;
    logic               bt_sync;
    logic               btn_db;
    logic               btn_db_q;
    logic [DEB_W-1:0]   deb_cnt;
    logic [1:0]         fill_cnt;
    logic               press_block;
    logic [3:0]         level;
    logic [STEP_W-1:0]  step_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               first_flight;

    logic               btn_rise;
    logic               btn_fall;
    logic               step_wrap;
    logic               at_max;
    logic [15:0]        v_calc;
    logic [7:0]         v_sat;

    // A rise is only a press once the post-reset release guard has cleared
    assign btn_rise  = btn_db & ~btn_db_q & ~press_block;
    assign btn_fall  = ~btn_db & btn_db_q;
    assign step_wrap = (step_cnt == STEP_LAST);
    assign at_max    = (level == MAX_LVL);
    assign v_calc    = 16'(V_MIN) + 16'(V_STEP) * {12'd0, level};
    assign v_sat     = (v_calc > 16'd255) ? 8'hFF : v_calc[7:0];

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            bt_meta <= 1'b0;
            bt_sync <= 1'b0;
        end else begin
            bt_meta <= i_bt;
            bt_sync <= bt_meta;
        end
    end

    // Debounce: follow the synced button only after a full run of consecutive mismatches
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (bt_sync != btn_db) begin
                if (deb_cnt == DEB_LAST) begin
                    btn_db  <= bt_sync;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Release guard: a button held through reset must be seen released before a press counts.
    // fill_cnt waits for the synchronizer to refill with the real button level.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt    <= 2'd0;
            press_block <= 1'b1;
        end else begin
            if (fill_cnt != 2'd2) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
            if (press_block && fill_cnt == 2'd2 && !bt_sync && !btn_db) begin
                press_block <= 1'b0;
            end
        end
    end

    // Main sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            level         <= 4'd0;
            step_cnt      <= '0;
            tmo_cnt       <= '0;
            first_flight  <= 1'b0;
            o_jump_en     <= 1'b0;
            o_jump_v_init <= 8'd0;
            o_squeeze     <= 4'd0;
            o_busy        <= 1'b0;
            o_land_pulse  <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_land_pulse <= 1'b0;
            o_timeout    <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_squeeze <= 4'd0;
                    if (btn_rise && i_arm) begin
                        state    <= S_CHARGE;
                        o_busy   <= 1'b1;
                        step_cnt <= '0;
                        level    <= 4'd0;
                    end
                end
                S_CHARGE: begin
                    if (!i_arm) begin
                        state     <= S_IDLE;
                        o_busy    <= 1'b0;
                        level     <= 4'd0;
                        o_squeeze <= 4'd0;
                        step_cnt  <= '0;
                    end else if (btn_fall) begin
                        state <= S_LAUNCH;
                    end else if (step_wrap) begin
                        step_cnt <= '0;
`ifdef JUMP_CHARGE_AUTOLAUNCH_EN
                        if (at_max) begin
                            state <= S_LAUNCH;
                        end else begin
                            level     <= level + 4'd1;
                            o_squeeze <= level + 4'd1;
                        end
`else
                        if (!at_max) begin
                            level     <= level + 4'd1;
                            o_squeeze <= level + 4'd1;
                        end
`endif
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end
                S_LAUNCH: begin
                    o_jump_v_init <= v_sat;
                    o_squeeze     <= 4'd0;
                    level         <= 4'd0;
                    o_jump_en     <= 1'b1;
                    tmo_cnt       <= '0;
                    first_flight  <= 1'b1;
                    state         <= S_FLIGHT;
                end
                S_FLIGHT: begin
                    // done in the first cycle may be stale from the previous trajectory
                    first_flight <= 1'b0;
                    if (!first_flight && i_jump_done) begin
                        state        <= S_DONE;
                        o_jump_en    <= 1'b0;
                        o_land_pulse <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= S_DONE;
                        o_jump_en <= 1'b0;
                        o_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    o_busy    <= 1'b0;
                    o_jump_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_charge_ctrl.sv
// tb/tb_jump_charge_ctrl.sv - Scoreboard testbench for jump_charge_ctrl
module tb_jump_charge_ctrl;

    localparam int DEB   = 4;
    localparam int STEP  = 8;
    localparam int MAXL  = 14;
    localparam int VMIN  = 20;
    localparam int VSTEP = 10;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_bt;
    logic       i_arm;
    logic       i_jump_done;

    logic       o_jump_en;
    logic [7:0] o_jump_v_init;
    logic [3:0] o_squeeze;
    logic       o_busy;
    logic       o_land_pulse;
    logic       o_timeout;

    logic       o_jump_en2;
    logic [7:0] o_jump_v_init2;
    logic [3:0] o_squeeze2;
    logic       o_busy2;
    logic       o_land_pulse2;
    logic       o_timeout2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] v1;
        logic [7:0] v2;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jump_charge_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .CHARGE_STEP(STEP), .MAX_LEVEL(MAXL),
        .V_MIN(VMIN), .V_STEP(VSTEP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .i_bt(i_bt), .i_arm(i_arm), .i_jump_done(i_jump_done),
        .o_jump_en(o_jump_en), .o_jump_v_init(o_jump_v_init), .o_squeeze(o_squeeze),
        .o_busy(o_busy), .o_land_pulse(o_land_pulse), .o_timeout(o_timeout)
    );

    jump_charge_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .CHARGE_STEP(STEP), .MAX_LEVEL(MAXL),
        .V_MIN(VMIN), .V_STEP(20), .TIMEOUT_CYCLES(TMO)
    ) dut2 (
        .clk(clk), .rst(rst), .i_bt(i_bt), .i_arm(i_arm), .i_jump_done(i_jump_done),
        .o_jump_en(o_jump_en2), .o_jump_v_init(o_jump_v_init2), .o_squeeze(o_squeeze2),
        .o_busy(o_busy2), .o_land_pulse(o_land_pulse2), .o_timeout(o_timeout2)
    );

    function automatic logic [7:0] exp_v(input int vstep, input int lvl);
        int v;
        v = VMIN + vstep * lvl;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic land, input int lvl);
        exp_t e;
        e.kind = {land, ~land};
        e.v1   = exp_v(VSTEP, lvl);
        e.v2   = exp_v(20, lvl);
        exp_q.push_back(e);
    endtask

    // Scoreboard: every completion pulse is matched against the next queued outcome
    always @(negedge clk) begin
        if (!rst && (o_land_pulse || o_timeout)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: land=%0b timeout=%0b v=%0d, required no completion", o_land_pulse, o_timeout, o_jump_v_init);
            end else begin
                sb_e = exp_q.pop_front();
                if ({o_land_pulse, o_timeout} !== sb_e.kind || o_jump_v_init !== sb_e.v1 || o_jump_v_init2 !== sb_e.v2) begin
                    n_fail++;
                    $display("FAIL sb_outcome: got kind=%b v=%0d v2=%0d, required kind=%b v=%0d v2=%0d",
                             {o_land_pulse, o_timeout}, o_jump_v_init, o_jump_v_init2, sb_e.kind, sb_e.v1, sb_e.v2);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; i_bt = 1'b0; i_arm = 1'b0; i_jump_done = 1'b0;
        cyc(3);
        n_cmp++; if (o_jump_en !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %0b required 0", o_jump_en); end
        n_cmp++; if (o_jump_v_init !== 8'd0) begin n_fail++; $display("FAIL rst_v_init: got %0d required 0", o_jump_v_init); end
        n_cmp++; if (o_squeeze !== 4'd0) begin n_fail++; $display("FAIL rst_squeeze: got %0d required 0", o_squeeze); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", o_busy); end
        n_cmp++; if ({o_land_pulse, o_timeout} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b required 00", {o_land_pulse, o_timeout}); end
        rst = 1'b0;
        cyc(4);
    endtask

    task automatic test_basic_jump();
        i_arm = 1'b1;
        cyc(2);
        i_bt = 1'b1;
        cyc(6);
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL press_early: busy got %0b required 0", o_busy); end
        cyc(1);
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL press_charge: busy got %0b required 1", o_busy); end
        cyc(16);
        n_cmp++; if (o_squeeze !== 4'd2) begin n_fail++; $display("FAIL squeeze_16: got %0d required 2", o_squeeze); end
        cyc(18);
        i_bt = 1'b0;
        push_exp(1'b1, 5);
        cyc(6);
        n_cmp++; if (o_squeeze !== 4'd5) begin n_fail++; $display("FAIL squeeze_40: got %0d required 5", o_squeeze); end
        cyc(1);
        n_cmp++; if (o_jump_en !== 1'b0) begin n_fail++; $display("FAIL launch_en: got %0b required 0", o_jump_en); end
        cyc(1);
        n_cmp++; if (o_jump_en !== 1'b1) begin n_fail++; $display("FAIL flight_en: got %0b required 1", o_jump_en); end
        n_cmp++; if (o_jump_v_init !== 8'd70 || o_jump_v_init2 !== 8'd120) begin n_fail++; $display("FAIL flight_v: got %0d/%0d required 70/120", o_jump_v_init, o_jump_v_init2); end
        n_cmp++; if (o_squeeze !== 4'd0) begin n_fail++; $display("FAIL flight_squeeze: got %0d required 0", o_squeeze); end
        cyc(29);
        n_cmp++; if (o_jump_en !== 1'b1) begin n_fail++; $display("FAIL flight_hold_en: got %0b required 1", o_jump_en); end
        i_jump_done = 1'b1;
        cyc(1);
        n_cmp++; if (o_land_pulse !== 1'b1 || o_jump_en !== 1'b0) begin n_fail++; $display("FAIL land: got land=%0b en=%0b required 1/0", o_land_pulse, o_jump_en); end
        i_jump_done = 1'b0;
        cyc(1);
        n_cmp++; if (o_land_pulse !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL land_idle: got land=%0b busy=%0b required 0/0", o_land_pulse, o_busy); end
        n_cmp++; if (o_jump_v_init !== 8'd70) begin n_fail++; $display("FAIL v_hold: got %0d required 70", o_jump_v_init); end
        cyc(4);
    endtask

    task automatic test_bounce();
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) i_bt = ~i_bt;
            cyc(1);
            if (o_busy || o_jump_en || o_squeeze != 4'd0 || o_land_pulse || o_timeout || dut.btn_db) bad++;
        end
        cyc(8);
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL bounce_cycles: got %0d active cycles required 0", bad); end
        n_cmp++; if (dut.btn_db !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL bounce_end: got db=%0b busy=%0b required 0/0", dut.btn_db, o_busy); end
    endtask

    task automatic test_saturation();
        i_bt = 1'b1;
        cyc(7);
        push_exp(1'b1, MAXL);
`ifdef JUMP_CHARGE_AUTOLAUNCH_EN
        cyc(119);
        n_cmp++; if (o_jump_en !== 1'b0 || o_squeeze !== 4'd14) begin n_fail++; $display("FAIL auto_pre: got en=%0b sq=%0d required 0/14", o_jump_en, o_squeeze); end
        cyc(2);
        n_cmp++; if (o_jump_en !== 1'b1) begin n_fail++; $display("FAIL auto_launch: got en=%0b required 1", o_jump_en); end
        n_cmp++; if (o_jump_v_init !== 8'd160 || o_jump_v_init2 !== 8'd255) begin n_fail++; $display("FAIL auto_v: got %0d/%0d required 160/255", o_jump_v_init, o_jump_v_init2); end
        i_bt = 1'b0;
        cyc(10);
        n_cmp++; if (o_jump_en !== 1'b1) begin n_fail++; $display("FAIL auto_release: got en=%0b required 1", o_jump_en); end
`else
        cyc(300);
        n_cmp++; if (o_squeeze !== 4'd14 || o_busy !== 1'b1) begin n_fail++; $display("FAIL sat_squeeze: got sq=%0d busy=%0b required 14/1", o_squeeze, o_busy); end
        i_bt = 1'b0;
        cyc(8);
        n_cmp++; if (o_jump_en !== 1'b1) begin n_fail++; $display("FAIL sat_en: got %0b required 1", o_jump_en); end
        n_cmp++; if (o_jump_v_init !== 8'd160 || o_jump_v_init2 !== 8'd255) begin n_fail++; $display("FAIL sat_v: got %0d/%0d required 160/255", o_jump_v_init, o_jump_v_init2); end
        cyc(5);
`endif
        i_jump_done = 1'b1;
        cyc(1);
        i_jump_done = 1'b0;
        cyc(8);
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL sat_idle: busy got %0b required 0", o_busy); end
    endtask

    task automatic test_disarm();
        int en_seen = 0;
        i_bt = 1'b1;
        cyc(7);
        cyc(20);
        i_bt = 1'b0;
        cyc(6);
        i_arm = 1'b0;
        cyc(1);
        n_cmp++; if (o_busy !== 1'b0 || o_squeeze !== 4'd0) begin n_fail++; $display("FAIL disarm: got busy=%0b sq=%0d required 0/0", o_busy, o_squeeze); end
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (o_jump_en) en_seen++;
        end
        n_cmp++; if (en_seen !== 0) begin n_fail++; $display("FAIL disarm_en: got %0d enabled cycles required 0", en_seen); end
        i_bt = 1'b1;
        cyc(12);
        i_arm = 1'b1;
        cyc(10);
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL held_at_arm: busy got %0b required 0", o_busy); end
        i_bt = 1'b0;
        cyc(10);
    endtask

    task automatic test_timeout();
        i_bt = 1'b1;
        cyc(7);
        i_bt = 1'b0;
        push_exp(1'b0, 0);
        cyc(8);
        i_jump_done = 1'b1;
        cyc(1);
        i_jump_done = 1'b0;
        n_cmp++; if (o_jump_en !== 1'b1 || o_land_pulse !== 1'b0) begin n_fail++; $display("FAIL stale_done: got en=%0b land=%0b required 1/0", o_jump_en, o_land_pulse); end
        cyc(98);
        n_cmp++; if (o_jump_en !== 1'b1 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got en=%0b tmo=%0b required 1/0", o_jump_en, o_timeout); end
        cyc(1);
        n_cmp++; if (o_timeout !== 1'b1 || o_jump_en !== 1'b0 || o_land_pulse !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got tmo=%0b en=%0b land=%0b required 1/0/0", o_timeout, o_jump_en, o_land_pulse); end
        cyc(1);
        n_cmp++; if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got tmo=%0b busy=%0b required 0/0", o_timeout, o_busy); end
        cyc(4);
    endtask

    task automatic test_reset_flight();
        i_bt = 1'b1;
        cyc(7);
        i_bt = 1'b0;
        cyc(8);
        i_bt = 1'b1;
        cyc(10);
        n_cmp++; if (o_jump_en !== 1'b1) begin n_fail++; $display("FAIL rf_flight: en got %0b required 1", o_jump_en); end
        rst = 1'b1;
        cyc(1);
        n_cmp++; if ({o_jump_en, o_jump_v_init, o_squeeze, o_busy, o_land_pulse, o_timeout} !== 16'd0) begin
            n_fail++; $display("FAIL rf_outputs: got en=%0b v=%0d sq=%0d busy=%0b required all 0", o_jump_en, o_jump_v_init, o_squeeze, o_busy);
        end
        rst = 1'b0;
        cyc(30);
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rf_held: busy got %0b required 0", o_busy); end
        i_bt = 1'b0;
        cyc(10);
        i_bt = 1'b1;
        cyc(7);
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rf_repress: busy got %0b required 1", o_busy); end
        i_arm = 1'b0;
        cyc(1);
        i_bt = 1'b0;
        i_arm = 1'b1;
        cyc(10);
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rf_end: busy got %0b required 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_basic_jump();
        test_bounce();
        test_saturation();
        test_disarm();
        test_timeout();
        test_reset_flight();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending outcomes required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
